// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column scan, debounced press/release,
// and a two-digit history of accepted keys for the display.
module keypad_scanner #(
    parameter int SCAN_COUNT     = 48000,
    parameter int DEBOUNCE_COUNT = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int CNT_MAX = (SCAN_COUNT > DEBOUNCE_COUNT) ? SCAN_COUNT : DEBOUNCE_COUNT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_COUNT - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_COUNT - 1);

    // state    | meaning
    // SCAN     | stepping columns, rows sampled on the last cycle of each dwell
    // DEBOUNCE | candidate key found, column frozen, waiting for a stable press
    // HELD     | key accepted, waiting for the row to go high
    // RELEASE  | row high, waiting for a stable release
    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_sync1, r_sync2;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_col, w_col_nxt, r_row, w_row_nxt, w_low_row;
    logic             w_any_low, w_row_low, w_accept, w_release_done;
    logic [3:0]       r_cols, r_key, r_digit_new, r_digit_old, w_key_code;
    logic             r_key_valid, r_key_held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= rows;
            r_sync2 <= r_sync1;
        end
    end

    assign w_any_low = ~&r_sync2;
    assign w_row_low = ~r_sync2[r_row];

    always_comb begin
        w_low_row = 2'd3;
        if (!r_sync2[0])      w_low_row = 2'd0;
        else if (!r_sync2[1]) w_low_row = 2'd1;
        else if (!r_sync2[2]) w_low_row = 2'd2;
    end

    always_comb begin
        w_key_code = 4'h0;
        case ({r_row, r_col})
            4'h0: w_key_code = 4'h1;
            4'h1: w_key_code = 4'h2;
            4'h2: w_key_code = 4'h3;
            4'h3: w_key_code = 4'hA;
            4'h4: w_key_code = 4'h4;
            4'h5: w_key_code = 4'h5;
            4'h6: w_key_code = 4'h6;
            4'h7: w_key_code = 4'hB;
            4'h8: w_key_code = 4'h7;
            4'h9: w_key_code = 4'h8;
            4'hA: w_key_code = 4'h9;
            4'hB: w_key_code = 4'hC;
            4'hC: w_key_code = 4'hE;
            4'hD: w_key_code = 4'h0;
            4'hE: w_key_code = 4'hF;
            4'hF: w_key_code = 4'hD;
            default: w_key_code = 4'h0;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_accept       = 1'b0;
        w_release_done = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (r_cnt == SCAN_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_any_low) begin
                        w_row_nxt   = w_low_row;
                        w_state_nxt = ST_DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_row_low) begin
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = '0;
                    w_col_nxt   = r_col + 2'd1;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_row_low) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                if (w_row_low) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt    = ST_SCAN;
                    w_cnt_nxt      = '0;
                    w_col_nxt      = 2'd0;
                    w_release_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_SCAN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_cols      <= 4'b1110;
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_digit_new <= 4'h0;
            r_digit_old <= 4'h0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            // Decoded from the next column so the pin is a flop output, one-cold
            r_cols      <= ~(4'b0001 << w_col_nxt);
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key       <= w_key_code;
                r_digit_new <= w_key_code;
                r_digit_old <= r_digit_new;
                r_key_held  <= 1'b1;
            end else if (w_release_done) begin
                r_key_held  <= 1'b0;
            end
        end
    end

    assign cols      = r_cols;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a scoreboard of accepted keys.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [15:0] press;            // bit r*4+c = key at row r, column c is down
    logic [11:0] sb_q[$];          // {key, digit_new, digit_old}
    logic [3:0]  exp_new, exp_old;
    int          n_vec, n_err, n_pulse;

    keypad_scanner #(.SCAN_COUNT(4), .DEBOUNCE_COUNT(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key shorts its row to the column currently driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [3:0] code);
        sb_q.push_back({code, code, exp_new});
        exp_old = exp_new;
        exp_new = code;
    endtask

    task automatic wait_pulse(input int target, input int budget);
        for (int i = 0; i < budget && n_pulse < target; i++) step(1);
        check_val("pulse_count", n_pulse, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && key_held; i++) step(1);
        check_val("idle_held", key_held, 1'b0);
        step(4);
    endtask

    task automatic wait_col(input logic [3:0] pat);
        for (int i = 0; i < 40 && cols != pat; i++) step(1);
        check_val("wait_col", cols, pat);
    endtask

    always @(negedge clk) begin
        if (reset && key_valid) begin
            logic [11:0] e;
            n_pulse++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("sb_key", key, e[11:8]);
                check_val("sb_digit_new", digit_new, e[7:4]);
                check_val("sb_digit_old", digit_old, e[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_cols;
        n_vec = 0; n_err = 0; n_pulse = 0;
        exp_new = 4'h0; exp_old = 4'h0;
        press = 16'h0;
        reset = 1'b1;
        #2 reset = 1'b0;
        step(3);
        check_val("rst_cols", cols, 4'b1110);
        check_val("rst_key", key, 4'h0);
        check_val("rst_valid", key_valid, 1'b0);
        check_val("rst_held", key_held, 1'b0);
        check_val("rst_new", digit_new, 4'h0);
        check_val("rst_old", digit_old, 4'h0);

        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_cols = ~(4'b0001 << ((k / 4) % 4));
            check_val("scan_cols", cols, exp_cols);
        end

        // Key 5 with a release bounce in the middle
        push_expect(4'h5);
        press[5] = 1'b1;
        wait_pulse(1, 60);
        step(10);
        check_val("k5_held", key_held, 1'b1);
        check_val("k5_key", key, 4'h5);
        check_val("k5_new", digit_new, 4'h5);
        check_val("k5_old", digit_old, 4'h0);
        press[5] = 1'b0;
        step(5);
        check_val("k5_bounce_held", key_held, 1'b1);
        press[5] = 1'b1;
        step(10);
        check_val("k5_reheld", key_held, 1'b1);
        check_val("k5_no_repeat", n_pulse, 1);
        press[5] = 1'b0;
        step(18);
        check_val("k5_rel_held", key_held, 1'b1);
        step(1);
        check_val("k5_rel_done", key_held, 1'b0);
        check_val("k5_rel_cols", cols, 4'b1110);
        check_val("k5_sb_empty", sb_q.size(), 0);

        // Short press of 3 at column 2: debounce aborts, scanning resumes at column 3
        wait_col(4'b1011);
        press[2] = 1'b1;
        step(5);
        check_val("bnc_col_frozen", cols, 4'b1011);
        press[2] = 1'b0;
        step(2);
        check_val("bnc_still_deb", cols, 4'b1011);
        step(1);
        check_val("bnc_resume", cols, 4'b0111);
        step(30);
        check_val("bnc_no_pulse", n_pulse, 1);

        // 7 then A
        push_expect(4'h7);
        press[8] = 1'b1;
        wait_pulse(2, 60);
        check_val("k7_key", key, 4'h7);
        press[8] = 1'b0;
        wait_idle();
        push_expect(4'hA);
        press[3] = 1'b1;
        wait_pulse(3, 60);
        check_val("kA_new", digit_new, 4'hA);
        check_val("kA_old", digit_old, 4'h7);
        press[3] = 1'b0;
        wait_idle();

        // 1 held, then 6 added: only 1 is reported
        push_expect(4'h1);
        press[0] = 1'b1;
        wait_pulse(4, 60);
        press[6] = 1'b1;
        step(30);
        check_val("two_pulses", n_pulse, 4);
        check_val("two_key", key, 4'h1);
        press[0] = 1'b0;
        press[6] = 1'b0;
        wait_idle();
        step(20);
        check_val("two_quiet", n_pulse, 4);
        push_expect(4'h6);
        press[6] = 1'b1;
        wait_pulse(5, 60);
        check_val("k6_key", key, 4'h6);
        press[6] = 1'b0;
        wait_idle();

        // Reset on debounce cycle 10 of key 9
        wait_col(4'b1011);
        press[10] = 1'b1;
        step(14);
        check_val("mid_deb_cols", cols, 4'b1011);
        reset = 1'b0;
        #1;
        check_val("arst_cols", cols, 4'b1110);
        check_val("arst_key", key, 4'h0);
        check_val("arst_valid", key_valid, 1'b0);
        check_val("arst_held", key_held, 1'b0);
        check_val("arst_new", digit_new, 4'h0);
        check_val("arst_old", digit_old, 4'h0);
        exp_new = 4'h0;
        exp_old = 4'h0;
        step(5);
        press[10] = 1'b0;
        step(3);
        reset = 1'b1;
        step(40);
        check_val("arst_no_pulse", n_pulse, 5);

        // Row 3 key after reset: history restarts from zero
        push_expect(4'hD);
        press[15] = 1'b1;
        wait_pulse(6, 60);
        check_val("kD_new", digit_new, 4'hD);
        check_val("kD_old", digit_old, 4'h0);
        press[15] = 1'b0;
        wait_idle();
        check_val("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
